// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the NoC round-robin output-port arbiter.
package noc_arb_pkg;

    localparam int MAX_PORTS = 32;
    localparam int MAX_PW    = 5;
    localparam logic [2:0] DEF_HEADER_ID = 3'b001;

    typedef enum logic {
        ARB_IDLE,
        ARB_HOLD
    } arb_state_t;

    // First set bit of r in order p+1, p+2, ... wrapping at n; -1 when none.
    function automatic int rr_next(input logic [MAX_PORTS-1:0] r, input int n, input int p);
        logic [MAX_PW:0] idx;
        int              found;
        found = -1;
        for (int k = 1; k <= MAX_PORTS; k++) begin
            if (k <= n && found < 0) begin
                idx = (MAX_PW+1)'(p) + (MAX_PW+1)'(k);
                if (idx >= (MAX_PW+1)'(n)) idx = idx - (MAX_PW+1)'(n);
                if (r[idx[MAX_PW-1:0]]) found = int'(idx);
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/noc_arb_timer.sv
// Per-channel packet timeout: header-loaded limit and a saturating hold counter.
module noc_arb_timer #(
    parameter int LEN_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] length,
    input  logic             run,
    input  logic             clear,
    output logic             expire
);

    logic [LEN_W-1:0] tlen;
    logic [LEN_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tlen  <= '0;
            count <= '0;
        end else begin
            if (load) tlen <= length;
            if (clear) count <= '0;
            else if (run && count != '1) count <= count + 1'b1;
        end
    end

    // A zero limit disables the timeout; a saturated count can still match a max limit.
    assign expire = (tlen != '0) && (count == tlen);

endmodule

// File: rtl/noc_rr_arbiter.sv
// Round-robin output-port arbiter with per-packet timeout and registered one-hot grant.
module noc_rr_arbiter
    import noc_arb_pkg::*;
#(
    parameter int NPORTS = 5,
    parameter int LEN_W  = 12,
    parameter int ID_W   = 3,
    parameter logic [ID_W-1:0] HEADER_ID = ID_W'(DEF_HEADER_ID)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NPORTS-1:0]       req,
    input  logic [NPORTS*ID_W-1:0]  flit_id,
    input  logic [NPORTS*LEN_W-1:0] length,
    output logic [NPORTS-1:0]       grant,
    output logic [NPORTS-1:0]       timeout,
    output logic                    busy
);

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    arb_state_t        state, state_nxt;
    logic [PW-1:0]     ptr, ptr_nxt;
    logic [NPORTS-1:0] grant_nxt, timeout_nxt, excl, expire;
    int                nxt;

    for (genvar i = 0; i < NPORTS; i++) begin : g_timer
        noc_arb_timer #(.LEN_W(LEN_W)) u_timer (
            .clk    (clk),
            .rst    (rst),
            .load   (flit_id[i*ID_W +: ID_W] == HEADER_ID),
            .length (length[i*LEN_W +: LEN_W]),
            .run    (grant_nxt[i]),
            .clear  (~grant_nxt[i]),
            .expire (expire[i])
        );
    end

    always_comb begin
        state_nxt   = ARB_IDLE;
        ptr_nxt     = ptr;
        grant_nxt   = '0;
        timeout_nxt = '0;
        excl        = '0;
        nxt         = -1;
        case (state)
            ARB_IDLE: nxt = rr_next(MAX_PORTS'(req), NPORTS, int'(ptr));
            ARB_HOLD: begin
                if (req[ptr] && !expire[ptr]) begin
                    nxt = int'(ptr);
                end else begin
                    // Holder sits out this decision only; a still-requesting holder timed out.
                    excl[ptr]        = 1'b1;
                    timeout_nxt[ptr] = req[ptr];
                    nxt = rr_next(MAX_PORTS'(req & ~excl), NPORTS, int'(ptr));
                end
            end
            default: ;
        endcase
        if (nxt >= 0) begin
            ptr_nxt            = PW'(nxt);
            grant_nxt[ptr_nxt] = 1'b1;
            state_nxt          = ARB_HOLD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ARB_IDLE;
            ptr     <= PW'(NPORTS - 1);
            grant   <= '0;
            timeout <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            grant   <= grant_nxt;
            timeout <= timeout_nxt;
            busy    <= |grant_nxt;
        end
    end

endmodule
